// File: rtl/thd_uart_tx.sv
// THD result logger: latches a 40-bit THD value, converts it to 13 BCD digits by
// sequential double-dabble, then sends the digits as ASCII plus CR LF over 8N1 UART.
module thd_uart_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [39:0] thd_in,
    input  logic        thd_trig,
    output logic        uart_txd,
    output logic        busy,
    output logic        done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_TX   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [5:0] LAST_ITER = 6'd39;
    localparam logic [3:0] LAST_BYTE = 4'd14;
    localparam logic [3:0] BYTE_END  = 4'd10;   // stop bit of the current byte has fully elapsed
    localparam logic [3:0] STOP_BIT  = 4'd9;

    logic [1:0]       state;
    logic             trig_d;
    logic             trig_edge;
    logic [39:0]      bin_sr;
    logic [51:0]      bcd;
    logic [51:0]      bcd_adj;
    logic [5:0]       iter_cnt;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [3:0]       byte_idx;
    logic [3:0]       next_idx;
    logic [7:0]       tx_data;
    logic [7:0]       next_char;

    assign trig_edge = thd_trig && !trig_d && (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign next_idx  = (bit_idx == BYTE_END) ? byte_idx + 4'd1 : byte_idx;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < 13; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // Byte about to start: digits 12..0 most significant first, then CR, then LF.
    always_comb begin
        next_char = 8'h30;
        case (next_idx)
            4'd13:   next_char = 8'h0D;
            4'd14:   next_char = 8'h0A;
            default: begin
                for (int d = 0; d < 13; d++) begin
                    if (next_idx == 4'(12 - d)) begin
                        next_char = {4'h3, bcd[4*d +: 4]};
                    end
                end
            end
        endcase
    end

    // NOTE: datapath registers are reset too, so an aborted frame leaves nothing behind for the next one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            trig_d   <= 1'b0;
            bin_sr   <= '0;
            bcd      <= '0;
            iter_cnt <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_data  <= '0;
            uart_txd <= 1'b1;
            done     <= 1'b0;
        end else begin
            trig_d <= thd_trig;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trig_edge) begin
                        state    <= S_CONV;
                        bin_sr   <= thd_in;
                        bcd      <= '0;
                        iter_cnt <= '0;
                    end
                end
                S_CONV: begin
                    {bcd, bin_sr} <= {bcd_adj[50:0], bin_sr, 1'b0};
                    iter_cnt      <= iter_cnt + 6'd1;
                    if (iter_cnt == LAST_ITER) begin
                        state    <= S_TX;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                    end
                end
                S_TX: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end else if (bit_idx == BYTE_END && byte_idx == LAST_BYTE) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        baud_cnt <= BIT_RELOAD;
                        if (bit_idx == 4'd0 || bit_idx == BYTE_END) begin
                            uart_txd <= 1'b0;
                            tx_data  <= next_char;
                            byte_idx <= next_idx;
                            bit_idx  <= 4'd1;
                        end else if (bit_idx == STOP_BIT) begin
                            uart_txd <= 1'b1;
                            bit_idx  <= BYTE_END;
                        end else begin
                            uart_txd <= tx_data[0];
                            tx_data  <= {1'b0, tx_data[7:1]};
                            bit_idx  <= bit_idx + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thd_uart_tx.sv
// Bench for thd_uart_tx: random THD values, decimal reference model feeding a byte
// scoreboard, independent UART receiver popping and comparing, plus frame timing checks.
module tb_thd_uart_tx;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        thd_trig  = 1'b0;
    logic [39:0] thd_in    = '0;
    logic        uart_txd;
    logic        busy;
    logic        done;

    thd_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .thd_in   (thd_in),
        .thd_trig (thd_trig),
        .uart_txd (uart_txd),
        .busy     (busy),
        .done     (done)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_cmp       = 0;
    int         n_bad       = 0;
    int         done_cnt    = 0;
    int         idle_low    = 0;
    int         frames_done = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits by repeated division, 13 digits MSB first, then CR LF.
    function automatic void push_expected(input logic [39:0] v);
        logic [63:0] x;
        logic [7:0]  digits[13];
        x = 64'(v);
        for (int i = 0; i < 13; i++) begin
            digits[i] = 8'h30 + 8'(x % 64'd10);
            x         = x / 64'd10;
        end
        for (int i = 12; i >= 0; i--) exp_q.push_back(digits[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    function automatic logic [39:0] rand40();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[39:0];
    endfunction

    // UART receiver / scoreboard monitor, sampling at bit centres on the falling clock edge.
    logic       rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_byte   = '0;
    logic [7:0] rx_exp;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_active = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (!busy && !uart_txd) idle_low++;
            if (!rx_active) begin
                if (!uart_txd) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == 4) begin
                    check("rx_start_bit", 64'(uart_txd), 64'd0);
                end else if (rx_cnt >= 14 && rx_cnt <= 84 && (rx_cnt - 14) % 10 == 0) begin
                    rx_byte = {uart_txd, rx_byte[7:1]};
                end else if (rx_cnt == 94) begin
                    check("rx_stop_bit", 64'(uart_txd), 64'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rx_unexpected: got byte %02h, expected no byte at time %0t", rx_byte, $time);
                    end else begin
                        rx_exp = exp_q.pop_front();
                        check("rx_byte", 64'(rx_byte), 64'(rx_exp));
                    end
                    rx_active = 1'b0;
                end
            end
        end
    end

    // Caller is at a falling edge with thd_trig low; returns at the falling edge after DONE.
    task automatic send_frame(input logic [39:0] v, input bit hold, input bit poke);
        int glitches;
        int d0;
        glitches = 0;
        d0       = done_cnt;
        thd_in   = v;
        thd_trig = 1'b1;
        push_expected(v);
        @(posedge sys_clk);                     // accepting edge T
        @(negedge sys_clk);
        if (!hold) thd_trig = 1'b0;
        thd_in = rand40();
        for (int k = 1; k <= 40; k++) begin
            @(negedge sys_clk);
            if (k == 1) check("busy_conv", 64'(busy), 64'd1);
            if (!uart_txd) glitches++;
        end
        check("conv_txd_high", 64'(glitches), 64'd0);
        @(negedge sys_clk);
        check("start_bit_t41", 64'(uart_txd), 64'd0);
        if (poke) begin
            repeat (300) @(negedge sys_clk);
            thd_in   = rand40();
            thd_trig = 1'b1;
            repeat (100) @(negedge sys_clk);
            thd_trig = 1'b0;
            repeat (1099) @(negedge sys_clk);
        end else begin
            repeat (1499) @(negedge sys_clk);
        end
        check("done_early", 64'(done), 64'd0);
        @(negedge sys_clk);
        check("done_pulse", 64'(done), 64'd1);
        check("busy_in_done", 64'(busy), 64'd1);
        @(negedge sys_clk);
        check("done_width", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        check("frame_bytes_left", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(done_cnt - d0), 64'd1);
        frames_done++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        repeat (3) @(negedge sys_clk);
        check("reset_txd", 64'(uart_txd), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);

        send_frame(40'd0, 1'b0, 1'b0);
        repeat (5) @(negedge sys_clk);
        send_frame(40'd123456789, 1'b0, 1'b0);
        repeat (5) @(negedge sys_clk);
        send_frame(40'hFF_FFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(1, 30)) @(negedge sys_clk);
            send_frame(rand40(), 1'b0, 1'b0);
        end

        // Mid-frame edge is ignored; an edge one cycle after done starts the next frame.
        repeat (5) @(negedge sys_clk);
        send_frame(rand40(), 1'b0, 1'b1);
        send_frame(rand40(), 1'b0, 1'b0);

        // Trigger held high for 3000 cycles yields a single frame.
        repeat (5) @(negedge sys_clk);
        send_frame(rand40(), 1'b1, 1'b0);
        d = done_cnt;
        repeat (3000 - 1543) @(negedge sys_clk);
        check("held_no_retrigger", 64'(done_cnt - d), 64'd0);
        thd_trig = 1'b0;

        // Reset during byte 5 data bits aborts the frame at once.
        repeat (5) @(negedge sys_clk);
        thd_in   = rand40();
        thd_trig = 1'b1;
        push_expected(thd_in);
        @(posedge sys_clk);
        @(negedge sys_clk);
        thd_trig = 1'b0;
        repeat (570) @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_txd", 64'(uart_txd), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        d = done_cnt;
        repeat (2000) @(negedge sys_clk);
        check("post_reset_quiet_done", 64'(done_cnt - d), 64'd0);
        check("post_reset_busy", 64'(busy), 64'd0);
        send_frame(rand40(), 1'b0, 1'b0);

        repeat (20) @(negedge sys_clk);
        check("idle_txd_low", 64'(idle_low), 64'd0);
        check("total_frames", 64'(done_cnt), 64'(frames_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
